irq_timer_ctrl: RTL and testbench
=================================

# irq_timer_ctrl

Memory-mapped interrupt source that drives the core's `interrupter` input and answers the core's data-memory bus for a 16-byte register window. It contains two sources: a programmable down-counting timer and a debounced push-button. Each source sets a sticky pending bit, and the masked OR of the pending bits drives the interrupt line. The block sits beside data RAM on the core's memory bus; the top-level read mux selects `io_rdata` when `io_hit` is high.

## Interface
- `BASE_ADDR`, default 32'hFFFF_FF00: window base, 16-byte aligned.
- `DEBOUNCE_CYCLES`, default 20'd1_000_000: number of consecutive stable cycles required before the debounced button level changes; must be ≥1.
- `clk` input 1: main clock.
- `rst` input 1: synchronous, active-high reset.
- `mem_ren` input 1: core read enable.
- `mem_wen` input 1: core write enable.
- `mem_addr` input 32: core byte address.
- `mem_dout` input 32: core write data.
- `io_rdata` output 32: read data returned to the core.
- `io_hit` output 1: `mem_addr[31:4] == BASE_ADDR[31:4]`.
- `btn_raw` input 1: asynchronous, bouncy button input.
- `interrupter` output 1: registered, level interrupt request to the core.

## Operation
- Register select is `mem_addr[3:2]`. A write occurs when `mem_wen & io_hit`; a read when `mem_ren & io_hit`.
- **0x0 CTRL (R/W):** bit0 `tmr_en`, bit1 `tmr_ie`, bit2 `btn_ie`, bit3 `reload`. Bits [31:4] read 0.
- **0x4 PERIOD (R/W):** 32-bit reload value.
- **0x8 COUNT (R/W):** current timer value. A write loads the counter.
- **0xC STATUS:**
  - bit0 `tmr_pend` (R/W1C).
  - bit1 `btn_pend` (R/W1C).
  - bit2 `btn_lvl`, debounced level (RO).
  - Bits [31:3] read 0.
- **Timer:**
  - While `tmr_en` is set and COUNT is nonzero, COUNT decrements by 1 each cycle.
  - While `tmr_en` is set and COUNT is 0, `tmr_pend` is set. Then:
    - if `reload` is set, COUNT ← PERIOD;
    - otherwise `tmr_en` clears and COUNT stays at 0.
  - With `reload` set, expiries repeat every PERIOD+1 cycles. PERIOD = 0 with `reload` set gives an expiry every cycle.
- **Button:**
  - `btn_raw` passes through a 2-flop synchronizer to give `btn_s`.
  - A counter increments while `btn_s != btn_lvl` and resets to 0 whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES−1, `btn_lvl` ← `btn_s` and the counter clears.
  - A 0→1 transition of `btn_lvl` sets `btn_pend`.
- **Interrupt:** `interrupter` ← `(tmr_pend & tmr_ie) | (btn_pend & btn_ie)`. It stays high until software clears the pending bit or the enable.
- **Reads:** `io_rdata` is combinational from `mem_addr[3:2]` when `mem_ren & io_hit`; otherwise it is 0.
- **Simultaneous events:**
  - Hardware set and a W1C of the same pending bit in the same cycle: set wins, and the bit stays 1.
  - Software write to COUNT in the same cycle as a decrement or reload: the write wins.
  - Software write to CTRL in the same cycle as an expiry: the expiry is evaluated on the pre-write CTRL, so the pending bit is still set. The new CTRL value is then written, and it overrides the hardware clear of `tmr_en`.
  - A read in the same cycle as an update returns the pre-edge value.
  - `mem_ren` and `mem_wen` both high: both are performed.
- Reset mid-count or mid-debounce: all state returns to reset values at the next edge, and any in-progress bounce count is discarded.

## Timing
- **Reset values:** CTRL, PERIOD, COUNT, STATUS, synchronizer flops, debounce counter, `btn_lvl` and `interrupter` are all 0. `io_rdata` and `io_hit` are combinational.
- **Read latency:** 0 cycles (combinational).
- **Write latency:** visible in the register on the edge that ends the write cycle.
- **Timer expiry to `interrupter`:** `tmr_pend` is set at edge N, where COUNT was 0 during cycle N−1; `interrupter` rises at edge N+1.
- **W1C to `interrupter` low:** the pending bit clears at the write edge; `interrupter` falls one edge later.
- **Button to `tmr_pend`-style flag:** a stable `btn_raw` rising edge sets `btn_pend` 2 (sync) + DEBOUNCE_CYCLES edges later.

## Configuration
- `IRQ_BTN_EN` defined: the synchronizer, debounce counter, `btn_lvl`, `btn_pend` and `btn_ie` are implemented as described above.
- `IRQ_BTN_EN` undefined:
  - `btn_raw` is ignored and no button logic is synthesized.
  - CTRL bit2 and STATUS bits [2:1] read 0, and writes to them have no effect.
  - `interrupter` ← `tmr_pend & tmr_ie`.

## Test plan
- **Reset:** hold `rst` 2 cycles with `btn_raw`=1 → every register reads 0, `interrupter`=0, `io_rdata`=0.
- **One-shot timer:** write COUNT=5, then CTRL=0x3 → COUNT reads 4,3,2,1,0 → `tmr_pend`=1 and CTRL reads 0x2 → `interrupter`=1 the next cycle. W1C STATUS=0x1 → `interrupter`=0 one cycle after the clear.
- **Auto-reload:** PERIOD=3, COUNT=0, CTRL=0xB → `tmr_pend` set every 4 cycles. Issue W1C in the same cycle as an expiry → STATUS bit0 still reads 1.
- **Debounce** (DEBOUNCE_CYCLES=8, CTRL=0x4): toggle `btn_raw` every 3 cycles for 30 cycles → no `btn_pend`. Then hold `btn_raw`=1 → `btn_lvl`=1 and `btn_pend`=1 exactly 10 cycles after the hold begins, `interrupter`=1 the cycle after. Release the button → no new pend.
- **Bus decode:** read at BASE_ADDR+0x10 → `io_hit`=0 and `io_rdata`=0. Write 0xDEADBEEF to PERIOD, then read it back → 0xDEADBEEF. Write CTRL=0xFFFFFFFF → CTRL reads 0xF.
- **Mid-operation reset:** while COUNT=100 with `tmr_en` set, assert `rst` for 1 cycle → COUNT=0, CTRL=0, and no interrupt for 200 following cycles.

Source files
------------

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped interrupt source: down-counting timer plus debounced push-button.
// Define IRQ_BTN_EN to build the button synchronizer/debouncer; otherwise only the timer exists.
module irq_timer_ctrl #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FF00,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] io_rdata,
    output logic        io_hit,
    input  logic        btn_raw,
    output logic        interrupter
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DB_W   = 20;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PERIOD = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    logic [1:0]        sel;
    logic              wr;
    logic              rd;
    logic              tmr_en;
    logic              tmr_ie;
    logic              reload;
    logic              tmr_pend;
    logic [DATA_W-1:0] period;
    logic [DATA_W-1:0] count;
    logic              expire;
    logic              btn_ie;
    logic              btn_pend;
    logic              btn_lvl;
    logic              irq_c;

    assign io_hit = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign sel    = mem_addr[3:2];
    assign wr     = mem_wen & io_hit;
    assign rd     = mem_ren & io_hit;
    assign expire = tmr_en & (count == '0);
    assign irq_c  = (tmr_pend & tmr_ie) | (btn_pend & btn_ie);

    // Timer, CTRL/PERIOD/COUNT registers and interrupt line; bus writes come last so they win
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_en      <= 1'b0;
            tmr_ie      <= 1'b0;
            reload      <= 1'b0;
            tmr_pend    <= 1'b0;
            period      <= '0;
            count       <= '0;
            interrupter <= 1'b0;
        end else begin
            if (expire && !reload) tmr_en <= 1'b0;
            if (tmr_en) begin
                if (count != '0) count <= count - DATA_W'(1);
                else if (reload) count <= period;
            end
            if (expire) tmr_pend <= 1'b1;
            else if (wr && (sel == SEL_STATUS) && mem_dout[0]) tmr_pend <= 1'b0;
            if (wr) begin
                case (sel)
                    SEL_CTRL: begin
                        tmr_en <= mem_dout[0];
                        tmr_ie <= mem_dout[1];
                        reload <= mem_dout[3];
                    end
                    SEL_PERIOD: period <= mem_dout;
                    SEL_COUNT:  count  <= mem_dout;
                    default: ;
                endcase
            end
            interrupter <= irq_c;
        end
    end

`ifdef IRQ_BTN_EN
    logic            sync1;
    logic            btn_s;
    logic [DB_W-1:0] db_cnt;
    logic            db_done;

    assign db_done = (btn_s != btn_lvl) && (db_cnt == DEBOUNCE_CYCLES - DB_W'(1));

    // Two-flop synchronizer, then a level only changes after DEBOUNCE_CYCLES stable cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            btn_s    <= 1'b0;
            db_cnt   <= '0;
            btn_lvl  <= 1'b0;
            btn_pend <= 1'b0;
            btn_ie   <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            btn_s <= sync1;
            if (btn_s == btn_lvl) begin
                db_cnt <= '0;
            end else if (db_done) begin
                btn_lvl <= btn_s;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            if (db_done && btn_s) btn_pend <= 1'b1;
            else if (wr && (sel == SEL_STATUS) && mem_dout[1]) btn_pend <= 1'b0;
            if (wr && (sel == SEL_CTRL)) btn_ie <= mem_dout[2];
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, mem_addr[1:0], BASE_ADDR[3:0]};
`else
    assign btn_ie   = 1'b0;
    assign btn_pend = 1'b0;
    assign btn_lvl  = 1'b0;

    logic unused_bits;
    assign unused_bits = &{1'b0, mem_addr[1:0], BASE_ADDR[3:0], btn_raw, DEBOUNCE_CYCLES};
`endif

    // Combinational read mux; zero unless a read hits the window
    always_comb begin
        io_rdata = '0;
        if (rd) begin
            case (sel)
                SEL_CTRL:   io_rdata = {28'd0, reload, btn_ie, tmr_ie, tmr_en};
                SEL_PERIOD: io_rdata = period;
                SEL_COUNT:  io_rdata = count;
                default:    io_rdata = {29'd0, btn_lvl, btn_pend, tmr_pend};
            endcase
        end
    end
endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl: table-driven bus vectors plus timer/button/reset sequences.
module tb_irq_timer_ctrl;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef IRQ_BTN_EN
    localparam logic [31:0] CTRL_ALL = 32'h0000_000F;
`else
    localparam logic [31:0] CTRL_ALL = 32'h0000_000B;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_dout = 32'd0;
    logic [31:0] io_rdata;
    logic        io_hit;
    logic        btn_raw = 1'b1;
    logic        interrupter;

    int n_checks = 0;
    int n_fail   = 0;

    irq_timer_ctrl #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(20'd8)) dut (
        .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .io_rdata(io_rdata),
        .io_hit(io_hit), .btn_raw(btn_raw), .interrupter(interrupter)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hit;
        logic [31:0] rdata;
        logic        irq;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] data);
        mem_addr = BASE + {28'd0, off};
        mem_dout = data;
        mem_wen  = 1'b1;
        tick();
        mem_wen  = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [3:0] off, input logic [31:0] exp);
        mem_addr = BASE + {28'd0, off};
        mem_ren  = 1'b1;
        #1;
        chk(name, io_rdata, exp);
        mem_ren  = 1'b0;
    endtask

    initial begin
        logic irq_seen;

        // Bus decode and register R/W vectors, applied one per cycle after reset
        vecs[0]  = '{1'b0, 1'b1, BASE + 32'h10, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 1'b1, BASE + 32'h18, 32'h1234_5678, 1'b0, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 1'b1, BASE + 32'h8,  32'h0,         1'b1, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 1'b0, BASE + 32'h4,  32'hDEAD_BEEF, 1'b1, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 1'b1, BASE + 32'h4,  32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, BASE + 32'h0,  32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 1'b1, BASE + 32'h0,  32'h0,         1'b1, CTRL_ALL,      1'b0};
        vecs[7]  = '{1'b1, 1'b1, BASE + 32'h0,  32'h0,         1'b1, CTRL_ALL,      1'b0};
        vecs[8]  = '{1'b0, 1'b1, BASE + 32'h8,  32'h0,         1'b1, 32'hDEAD_BEEE, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, BASE + 32'hC,  32'h0,         1'b1, 32'h1,         1'b0};
        vecs[10] = '{1'b1, 1'b1, BASE + 32'hC,  32'h1,         1'b1, 32'h1,         1'b0};
        vecs[11] = '{1'b0, 1'b1, BASE + 32'hC,  32'h0,         1'b1, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 1'b0, BASE + 32'h4,  32'h0,         1'b1, 32'h0,         1'b0};

        // Reset held two cycles with the button pressed
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        btn_raw = 1'b0;
        chk("reset irq", {31'd0, interrupter}, 32'd0);
        rdchk("reset CTRL", 4'h0, 32'd0);
        rdchk("reset PERIOD", 4'h4, 32'd0);
        rdchk("reset COUNT", 4'h8, 32'd0);
        rdchk("reset STATUS", 4'hC, 32'd0);
        mem_addr = BASE;
        #1;
        chk("idle rdata", io_rdata, 32'd0);

        for (int i = 0; i < 13; i++) begin
            mem_wen  = vecs[i].wen;
            mem_ren  = vecs[i].ren;
            mem_addr = vecs[i].addr;
            mem_dout = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d hit", i), {31'd0, io_hit}, {31'd0, vecs[i].hit});
            chk($sformatf("vec%0d rdata", i), io_rdata, vecs[i].rdata);
            chk($sformatf("vec%0d irq", i), {31'd0, interrupter}, {31'd0, vecs[i].irq});
            tick();
            mem_wen = 1'b0;
            mem_ren = 1'b0;
        end

        // One-shot timer
        wr(4'h8, 32'd5);
        wr(4'h0, 32'h3);
        for (int i = 0; i < 5; i++) begin
            tick();
            rdchk($sformatf("oneshot count%0d", i), 4'h8, 32'(4 - i));
        end
        rdchk("oneshot no early pend", 4'hC, 32'd0);
        tick();
        rdchk("oneshot pend", 4'hC, 32'h1);
        rdchk("oneshot ctrl en cleared", 4'h0, 32'h2);
        chk("oneshot irq not yet", {31'd0, interrupter}, 32'd0);
        tick();
        chk("oneshot irq", {31'd0, interrupter}, 32'd1);
        wr(4'hC, 32'h1);
        chk("w1c irq lag", {31'd0, interrupter}, 32'd1);
        tick();
        chk("w1c irq low", {31'd0, interrupter}, 32'd0);

        // Auto-reload, including W1C colliding with an expiry
        wr(4'h4, 32'd3);
        wr(4'h8, 32'd0);
        wr(4'h0, 32'hB);
        tick();
        rdchk("reload first pend", 4'hC, 32'h1);
        rdchk("reload count", 4'h8, 32'd3);
        wr(4'hC, 32'h1);
        rdchk("reload cleared", 4'hC, 32'h0);
        tick();
        tick();
        rdchk("reload count zero", 4'h8, 32'd0);
        wr(4'hC, 32'h1);
        rdchk("set beats w1c", 4'hC, 32'h1);
        rdchk("reload again", 4'h8, 32'd3);
        wr(4'hC, 32'h1);
        tick();
        tick();
        rdchk("reload no pend mid", 4'hC, 32'h0);
        tick();
        rdchk("reload period 4", 4'hC, 32'h1);
        wr(4'h0, 32'h0);
        wr(4'hC, 32'h1);

`ifdef IRQ_BTN_EN
        // Bouncing input never settles, then a clean press
        wr(4'h0, 32'h4);
        for (int i = 0; i < 10; i++) begin
            btn_raw = ~i[0];
            repeat (3) tick();
        end
        rdchk("bounce no pend", 4'hC, 32'h0);
        btn_raw = 1'b1;
        repeat (9) tick();
        rdchk("press before settle", 4'hC, 32'h0);
        tick();
        rdchk("press settled", 4'hC, 32'h6);
        chk("btn irq not yet", {31'd0, interrupter}, 32'd0);
        tick();
        chk("btn irq", {31'd0, interrupter}, 32'd1);
        wr(4'hC, 32'h2);
        rdchk("btn pend cleared", 4'hC, 32'h4);
        btn_raw = 1'b0;
        repeat (20) tick();
        rdchk("release no pend", 4'hC, 32'h0);
        chk("release irq", {31'd0, interrupter}, 32'd0);
        wr(4'h0, 32'h0);
`else
        // Without the button build, its bits stay 0 and the input is ignored
        wr(4'h0, 32'h4);
        rdchk("btn_ie absent", 4'h0, 32'h0);
        btn_raw = 1'b1;
        repeat (20) tick();
        rdchk("btn status absent", 4'hC, 32'h0);
        chk("btn irq absent", {31'd0, interrupter}, 32'd0);
        btn_raw = 1'b0;
`endif

        // Mid-operation reset
        wr(4'h8, 32'd200);
        wr(4'h0, 32'h3);
        wr(4'h8, 32'd100);
        rdchk("count write wins", 4'h8, 32'd100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdchk("midreset COUNT", 4'h8, 32'd0);
        rdchk("midreset CTRL", 4'h0, 32'd0);
        irq_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (interrupter !== 1'b0) irq_seen = 1'b1;
        end
        chk("midreset no irq", {31'd0, irq_seen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
